// File: rtl/bram_pkg.sv
// Shared constants, helpers and state encoding for the byte-write SDP block RAM family.
package bram_pkg;

    localparam string PERF_HIGH        = "HIGH_PERFORMANCE";
    localparam string PERF_LOW         = "LOW_LATENCY";
    localparam string COLL_READ_FIRST  = "READ_FIRST";
    localparam string COLL_WRITE_FIRST = "WRITE_FIRST";

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bram_state_e;

    // Address width never collapses to zero, so a 2-entry RAM still gets one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sdp_bram_core.sv
// Byte-enabled simple dual-port array with a registered read port and collision forwarding.
module sdp_bram_core
    import bram_pkg::*;
#(
    parameter int    RAM_WIDTH      = 32,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    RAM_DEPTH      = 64,
    parameter string COLLISION_MODE = "READ_FIRST",
    localparam int   NUM_BYTES      = RAM_WIDTH / BYTE_WIDTH,
    localparam int   ADDR_W         = clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstn,
    input  logic [NUM_BYTES-1:0] we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [RAM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [RAM_WIDTH-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(RAM_DEPTH);
    localparam bit              FWD_EN  = (COLLISION_MODE == COLL_WRITE_FIRST);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 collide;
    logic [RAM_WIDTH-1:0] rd_word;

    assign wr_ok   = {1'b0, waddr} < DEPTH_L;
    assign rd_ok   = {1'b0, raddr} < DEPTH_L;
    assign collide = FWD_EN && wr_ok && (waddr == raddr);

    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[raddr];
        end
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (collide && we[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // The array has no reset; known contents come from the clear sweep in the top level.
    always_ff @(posedge clka) begin
        if (wr_ok) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (we[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: rtl/sdp_bram_bytewrite_clr.sv
// Byte-write SDP RAM with post-reset clear sweep and a read-valid output pipeline.
//   state | meaning
//   CLEAR | sweeping zeros through the array, ports ignored, busy high
//   READY | normal read/write operation
module sdp_bram_bytewrite_clr
    import bram_pkg::*;
#(
    parameter int    RAM_WIDTH       = 32,
    parameter int    BYTE_WIDTH      = 8,
    parameter int    RAM_DEPTH       = 64,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string COLLISION_MODE  = "READ_FIRST",
    parameter int    CLEAR_ON_RESET  = 1,
    localparam int   NUM_BYTES       = RAM_WIDTH / BYTE_WIDTH,
    localparam int   ADDR_W          = clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstn,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [NUM_BYTES-1:0] wea,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic                 enb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 validb,
    output logic                 busy
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_DEPTH - 1);

    bram_state_e          state;
    bram_state_e          state_nxt;
    logic [ADDR_W-1:0]    clr_addr;
    logic [ADDR_W-1:0]    clr_addr_nxt;
    logic [NUM_BYTES-1:0] core_we;
    logic [ADDR_W-1:0]    core_waddr;
    logic [RAM_WIDTH-1:0] core_wdata;
    logic                 core_re;
    logic [RAM_WIDTH-1:0] stage1;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            CLEAR: begin
                clr_addr_nxt = clr_addr + ADDR_W'(1);
                if (clr_addr == CLR_LAST) begin
                    state_nxt    = READY;
                    clr_addr_nxt = '0;
                end
            end
            READY: begin
                state_nxt = READY;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // While clearing, the sweep owns the write port and reads are suppressed.
    assign core_we    = busy ? '1 : wea;
    assign core_waddr = busy ? clr_addr : addra;
    assign core_wdata = busy ? '0 : dina;
    assign core_re    = enb && !busy;

    sdp_bram_core #(
        .RAM_WIDTH     (RAM_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH),
        .COLLISION_MODE(COLLISION_MODE)
    ) u_core (
        .clka (clka),
        .rstn (rstn),
        .we   (core_we),
        .waddr(core_waddr),
        .wdata(core_wdata),
        .re   (core_re),
        .raddr(addrb),
        .rdata(stage1)
    );

    if (RAM_PERFORMANCE == PERF_LOW) begin : g_low_latency
        always_ff @(posedge clka or negedge rstn) begin
            if (!rstn) begin
                validb <= 1'b0;
            end else begin
                validb <= core_re;
            end
        end
        assign doutb = stage1;
    end else begin : g_high_perf
        logic                 valid_s1;
        logic [RAM_WIDTH-1:0] dout_q;

        // stage1 only moves on a read, so loading every cycle still holds between beats.
        always_ff @(posedge clka or negedge rstn) begin
            if (!rstn) begin
                valid_s1 <= 1'b0;
                validb   <= 1'b0;
                dout_q   <= '0;
            end else begin
                valid_s1 <= core_re;
                validb   <= valid_s1;
                dout_q   <= stage1;
            end
        end
        assign doutb = dout_q;
    end

endmodule

// File: tb/tb_sdp_bram_bytewrite_clr.sv
// Scoreboard bench: two configurations share stimulus, each checked against its own array model.
module tb_sdp_bram_bytewrite_clr;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rstn  = 1'b0;
    logic [3:0]  addra = '0;
    logic [3:0]  addrb = '0;
    logic [3:0]  wea   = '0;
    logic [31:0] dina  = '0;
    logic        enb   = 1'b0;

    logic [31:0] dout   [2];
    logic        validb [2];
    logic        busy   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clka) cyc <= cyc + 1;

    // Instance 0: depth 16, 2-cycle read, old data on collision.
    sdp_bram_bytewrite_clr #(
        .RAM_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(16),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .COLLISION_MODE("READ_FIRST"),
        .CLEAR_ON_RESET(1)
    ) u_hp_rf (
        .clka(clka), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .addrb(addrb), .enb(enb), .doutb(dout[0]), .validb(validb[0]), .busy(busy[0])
    );

    // Instance 1: depth 12 (non power of two), 1-cycle read, new bytes forwarded.
    sdp_bram_bytewrite_clr #(
        .RAM_WIDTH(32), .BYTE_WIDTH(8), .RAM_DEPTH(12),
        .RAM_PERFORMANCE("LOW_LATENCY"), .COLLISION_MODE("WRITE_FIRST"),
        .CLEAR_ON_RESET(1)
    ) u_ll_wf (
        .clka(clka), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .addrb(addrb), .enb(enb), .doutb(dout[1]), .validb(validb[1]), .busy(busy[1])
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [31:0] mem [2][16];
    int          busy_left [2];
    logic [31:0] last [2];

    function automatic int depth_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = depth_of(k);
            last[k]      = '0;
            // The sweep zeroes everything before the first legal access.
            for (int i = 0; i < 16; i++) mem[k][i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Applies the rules for the coming rising edge using the inputs just driven.
    task automatic model_edge();
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            chk("busy", k, {31'b0, busy[k]}, {31'b0, (busy_left[k] > 0)});
            if (busy_left[k] > 0) begin
                busy_left[k]--;
            end else begin
                if (enb) begin
                    b.data = '0;
                    if (int'(addrb) < depth_of(k)) begin
                        b.data = mem[k][addrb];
                        if (k == 1 && addra == addrb) begin
                            for (int i = 0; i < 4; i++)
                                if (wea[i]) b.data[i*8 +: 8] = dina[i*8 +: 8];
                        end
                    end
                    b.cyc = cyc + lat_of(k);
                    if (k == 0) q0.push_back(b);
                    else        q1.push_back(b);
                end
                if (int'(addra) < depth_of(k)) begin
                    for (int i = 0; i < 4; i++)
                        if (wea[i]) mem[k][addra][i*8 +: 8] = dina[i*8 +: 8];
                end
            end
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d);
        beat_t b;
        int    pending;
        pending = (k == 0) ? q0.size() : q1.size();
        if (v) begin
            if (pending == 0) begin
                total++;
                bad++;
                $display("FAIL valid_spurious inst%0d: validb=1 doutb=%h with no read outstanding (cycle %0d)", k, d, cyc);
            end else begin
                if (k == 0) b = q0.pop_front();
                else        b = q1.pop_front();
                chk("rd_data", k, d, b.data);
                chk("rd_cycle", k, cyc, b.cyc);
                last[k] = b.data;
            end
        end else begin
            chk("dout_hold", k, d, last[k]);
        end
    endtask

    always @(negedge clka) begin
        #1;
        mon(0, validb[0], dout[0]);
        mon(1, validb[1], dout[1]);
    end

    task automatic step(input logic [3:0] aa, input logic [31:0] d, input logic [3:0] w,
                        input logic [3:0] ab, input logic e);
        @(negedge clka);
        addra = aa;
        dina  = d;
        wea   = w;
        addrb = ab;
        enb   = e;
        model_edge();
    endtask

    task automatic garbage_step();
        step(4'($urandom_range(0, 15)), $urandom, 4'hF, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clka);
        rstn = 1'b0;
        model_reset();
        @(negedge clka);
        rstn  = 1'b1;
        addra = 4'($urandom_range(0, 15));
        dina  = $urandom;
        wea   = 4'hF;
        addrb = 4'($urandom_range(0, 15));
        enb   = 1'b1;
        model_edge();
    endtask

    initial begin
        logic [3:0] aa;
        logic [3:0] ab;
        model_reset();

        // Garbage writes and reads during the sweep, interrupted by a reset at cycle 7.
        do_reset();
        repeat (6) garbage_step();
        do_reset();
        repeat (15) garbage_step();

        for (int i = 0; i < 16; i++) step(4'd0, 32'd0, 4'h0, 4'(i), 1'b1);

        step(4'd3, 32'hAABBCCDD, 4'hF, 4'd0, 1'b0);
        step(4'd3, 32'h11223344, 4'b0101, 4'd0, 1'b0);
        step(4'd0, 32'd0, 4'h0, 4'd3, 1'b1);

        step(4'd5, 32'h12345678, 4'hF, 4'd0, 1'b0);
        step(4'd5, 32'hFFFFFFFF, 4'b0011, 4'd5, 1'b1);
        step(4'd0, 32'd0, 4'h0, 4'd5, 1'b1);

        step(4'd0, 32'hA0, 4'hF, 4'd0, 1'b0);
        step(4'd1, 32'hA1, 4'hF, 4'd0, 1'b0);
        step(4'd2, 32'hA2, 4'hF, 4'd0, 1'b0);
        step(4'd0, 32'd0, 4'h0, 4'd0, 1'b1);
        step(4'd0, 32'd0, 4'h0, 4'd1, 1'b1);
        step(4'd0, 32'd0, 4'h0, 4'd13, 1'b1);
        step(4'd0, 32'd0, 4'h0, 4'd2, 1'b1);
        step(4'd0, 32'd0, 4'h0, 4'd0, 1'b0);

        repeat (500) begin
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            step(aa, $urandom, 4'($urandom_range(0, 15)), ab, 1'($urandom_range(0, 1)));
        end

        // One more clear in the middle of traffic, then a short random tail.
        do_reset();
        repeat (15) garbage_step();
        repeat (100) begin
            aa = 4'($urandom_range(0, 15));
            ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15));
            step(aa, $urandom, 4'($urandom_range(0, 15)), ab, 1'($urandom_range(0, 1)));
        end

        repeat (4) step(4'd0, 32'd0, 4'h0, 4'd0, 1'b0);
        @(negedge clka);
        #2;
        chk("drained", 0, 32'(q0.size()), 32'd0);
        chk("drained", 1, 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
